// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and widths for the SRAM port arbiter
package sram_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic [3:0] WEN_READ = 4'b0000;
  localparam int LAT_W = $clog2(4 + 1);
  localparam int STARVE_W = $clog2(15 + 1);
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of fetch conflicts lost to data
module arb_starve_ctr import sram_arb_pkg::*; #(
  parameter int MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [STARVE_W-1:0] cnt;
  assign at_max = cnt == STARVE_W'(MAX);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (inc && !at_max) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous SRAM between fetch and data ports
module sram_port_arbiter import sram_arb_pkg::*; #(
  parameter int MEM_LAT = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        stall_inst,
  output logic        stall_data,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  state_t state;
  logic [LAT_W-1:0] lat_cnt;
  logic wr, idle, at_max, grant_i, grant_d, done;
  assign idle = state == IDLE && !rst;
  assign grant_i = idle && inst_req && (!data_req || at_max);
  assign grant_d = idle && data_req && !grant_i;
  assign done = !rst && state != IDLE && (wr || lat_cnt == LAT_W'(MEM_LAT));
  assign inst_ack = done && state == BUSY_I;
  assign data_ack = done && state == BUSY_D;
  assign inst_rdata = inst_ack ? mem_rdata : '0;
  assign data_rdata = data_ack ? mem_rdata : '0;
  assign stall_inst = inst_req && !inst_ack;
  assign stall_data = data_req && !data_ack;
  assign mem_en = grant_i || grant_d;
  assign mem_wen = grant_d ? data_wen : WEN_READ;
  assign mem_addr = grant_i ? inst_addr : grant_d ? data_addr : '0;
  assign mem_wdata = grant_d ? data_wdata : '0;
  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk(clk),
    .rst(rst),
    .inc(grant_d && inst_req),
    .clr(grant_i),
    .at_max(at_max)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      wr <= 1'b0;
    end else if (mem_en) begin
      state <= grant_i ? BUSY_I : BUSY_D;
      lat_cnt <= LAT_W'(1);
      wr <= grant_d && data_wen != WEN_READ;
    end else if (done) begin
      state <= IDLE;
      lat_cnt <= '0;
      wr <= 1'b0;
    end else if (state != IDLE)
      lat_cnt <= lat_cnt + 1'b1;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed vector and sequence bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int BOUND = (3 + 1) * (1 + 1) + 1;
  typedef struct {
    logic ir, dr;
    logic [3:0] wen;
    logic [31:0] ia, da, wd, rd;
    logic [136:0] e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic inst_req = 0, data_req = 0;
  logic [3:0] data_wen = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic [31:0] inst_rdata_3, data_rdata_3, mem_addr_3, mem_wdata_3;
  logic inst_ack, data_ack, stall_inst, stall_data, mem_en;
  logic inst_ack_3, data_ack_3, stall_inst_3, stall_data_3, mem_en_3;
  logic [3:0] mem_wen, mem_wen_3;
  logic [136:0] o1, o3;
  int n_vec = 0, n_bad = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u1 (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_ack(inst_ack), .data_req(data_req),
    .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ack(data_ack), .stall_inst(stall_inst),
    .stall_data(stall_data), .mem_en(mem_en), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) u3 (
    .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata_3), .inst_ack(inst_ack_3), .data_req(data_req),
    .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata_3), .data_ack(data_ack_3), .stall_inst(stall_inst_3),
    .stall_data(stall_data_3), .mem_en(mem_en_3), .mem_wen(mem_wen_3),
    .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata)
  );
  assign o1 = {mem_en, mem_wen, mem_addr, mem_wdata, inst_ack, data_ack,
               inst_rdata, data_rdata, stall_inst, stall_data};
  assign o3 = {mem_en_3, mem_wen_3, mem_addr_3, mem_wdata_3, inst_ack_3, data_ack_3,
               inst_rdata_3, data_rdata_3, stall_inst_3, stall_data_3};
  logic p_ir = 0, p_iack = 0, p_dr = 0, p_dack = 0, p_rst = 1;
  always @(negedge clk) begin
    assert (rst || p_rst || !p_ir || p_iack || inst_req)
      else $error("protocol: inst_req dropped before inst_ack");
    assert (rst || p_rst || !p_dr || p_dack || data_req)
      else $error("protocol: data_req dropped before data_ack");
    p_ir <= inst_req;
    p_iack <= inst_ack;
    p_dr <= data_req;
    p_dack <= data_ack;
    p_rst <= rst;
  end
  function automatic logic [136:0] ex(logic en, logic [3:0] mw, logic [31:0] ma, mwd,
                                      logic ik, dk, logic [31:0] ird, drd, logic si, sd);
    return {en, mw, ma, mwd, ik, dk, ird, drd, si, sd};
  endfunction
  function automatic vec_t mk(logic ir, dr, logic [3:0] wen, logic [31:0] ia, da, wd, rd,
                              logic [136:0] e);
    vec_t v;
    v.ir = ir; v.dr = dr; v.wen = wen; v.ia = ia; v.da = da; v.wd = wd; v.rd = rd; v.e = e;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [136:0] got, input logic [136:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1; inst_req = 0; data_req = 0; data_wen = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
    next_cycle();
    next_cycle();
    rst = 0;
  endtask
  initial begin
    int i_age, d_age, en_cnt, ack_cnt, bad_lat, bad_rd, bad_excl;
    logic li, ld, drain;
    q.push_back(mk(1, 0, 0, 32'hBFC00000, 0, 0, 0, ex(1, 0, 32'hBFC00000, 0, 0, 0, 0, 0, 1, 0)));
    q.push_back(mk(1, 0, 0, 32'hBFC00000, 0, 0, 32'h24080001,
                   ex(0, 0, 0, 0, 1, 0, 32'h24080001, 0, 0, 0)));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    q.push_back(mk(0, 1, 4'b0011, 0, 32'h80001000, 32'hDEADBEEF, 0,
                   ex(1, 4'b0011, 32'h80001000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1)));
    q.push_back(mk(0, 1, 4'b0011, 0, 32'h80001000, 32'hDEADBEEF, 0,
                   ex(0, 0, 0, 0, 0, 1, 0, 0, 0, 0)));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    for (int k = 0; k < 16; k++) begin
      logic oi;
      logic [31:0] rd;
      oi = ((k / 2) % 4) == 3;
      rd = 32'hA0000000 + k;
      q.push_back(mk(1, 1, 0, 32'h100, 32'h200, 0, rd, (k % 2 == 0) ?
                     ex(1, 0, oi ? 32'h100 : 32'h200, 0, 0, 0, 0, 0, 1, 1) :
                     ex(0, 0, 0, 0, oi, !oi, oi ? rd : 0, oi ? 0 : rd, !oi, oi)));
    end
    q.push_back(mk(0, 1, 0, 0, 32'h200, 0, 0, ex(1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 1)));
    q.push_back(mk(0, 1, 0, 0, 32'h200, 0, 32'hA0000100,
                   ex(0, 0, 0, 0, 0, 1, 0, 32'hA0000100, 0, 0)));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    next_cycle();
    @(negedge clk);
    chk("reset_lat1", o1, '0);
    chk("reset_lat3", o3, '0);
    next_cycle();
    rst = 0;
    foreach (q[n]) begin
      inst_req = q[n].ir; data_req = q[n].dr; data_wen = q[n].wen;
      inst_addr = q[n].ia; data_addr = q[n].da; data_wdata = q[n].wd; mem_rdata = q[n].rd;
      @(negedge clk);
      chk($sformatf("vec%0d", n), o1, q[n].e);
      next_cycle();
    end
    do_reset();
    data_req = 1; data_addr = 32'h80002000; data_wen = 0;
    @(negedge clk);
    chk("lat3_grant", {95'b0, mem_en_3, mem_addr_3, data_ack_3}, {95'b0, 1'b1, 32'h80002000, 1'b0});
    next_cycle();
    @(negedge clk);
    chk("lat3_t1", {135'b0, mem_en_3, data_ack_3}, '0);
    next_cycle();
    @(negedge clk);
    chk("lat3_t2", {135'b0, mem_en_3, data_ack_3}, '0);
    next_cycle();
    mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("lat3_ack", {103'b0, mem_en_3, data_ack_3, data_rdata_3}, {103'b0, 1'b0, 1'b1, 32'hCAFEF00D});
    next_cycle();
    mem_rdata = 0;
    @(negedge clk);
    chk("lat3_regrant", {135'b0, mem_en_3, data_ack_3}, {135'b0, 1'b1, 1'b0});
    next_cycle();
    rst = 1;
    @(negedge clk);
    chk("rst_t1_noack", {136'b0, data_ack_3}, '0);
    next_cycle();
    @(negedge clk);
    chk("rst_t2_outs", {o3[136:2], 2'b00}, '0);
    next_cycle();
    mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("rst_t3_outs", {o3[136:2], 2'b00}, '0);
    next_cycle();
    rst = 0; data_req = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rst_release", o3, '0);
    do_reset();
    i_age = 0; d_age = 0; en_cnt = 0; ack_cnt = 0; bad_lat = 0; bad_rd = 0; bad_excl = 0;
    li = 0; ld = 0; drain = 0;
    for (int c = 0; c < 3100; c++) begin
      if (c >= 3000) drain = 1;
      if (!inst_req || li) begin
        inst_req = !drain && $urandom_range(0, 2) != 0;
        inst_addr = $urandom;
        i_age = 0;
      end else i_age++;
      if (!data_req || ld) begin
        data_req = !drain && $urandom_range(0, 2) != 0;
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wen = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
        d_age = 0;
      end else d_age++;
      mem_rdata = $urandom;
      @(negedge clk);
      li = inst_ack; ld = data_ack;
      en_cnt += int'(mem_en);
      ack_cnt += int'(inst_ack) + int'(data_ack);
      if ((inst_ack && data_ack) || (mem_en && (inst_ack || data_ack))) bad_excl++;
      if ((inst_ack && i_age > BOUND) || (data_ack && d_age > BOUND)) bad_lat++;
      if ((inst_ack && inst_rdata !== mem_rdata) || (data_ack && data_rdata !== mem_rdata)) bad_rd++;
      next_cycle();
    end
    chk("rand_latency_viol", 137'(bad_lat), '0);
    chk("rand_rdata_viol", 137'(bad_rd), '0);
    chk("rand_exclusive_viol", 137'(bad_excl), '0);
    chk("rand_en_vs_ack", 137'(en_cnt), 137'(ack_cnt));
    chk("rand_drained", {135'b0, inst_req, data_req}, '0);
    chk("rand_activity", {136'b0, en_cnt > 500}, {136'b0, 1'b1});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
